pdm_decimator: RTL and testbench

Receive-side counterpart of the sigma-delta DAC chain. It takes a 1-bit PDM stream at the oversampled rate (128 x 44.1 kHz, PLL clock domain) and recovers signed 16-bit PCM samples at 44.1 kHz using a 3rd-order CIC decimator, scaling with saturation, and a valid/ready output handshake. It is used as a loopback checker on `output_pdm` and as the front end for an external PDM source.

---
 rtl/pdm_decimator.sv | 116 +++++++++++
 tb/tb_pdm_decimator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// pdm_decimator: 1-bit PDM to signed 16-bit PCM through a 3rd-order CIC
// decimator, arithmetic-shift scaling with saturation, and a valid/ready
// output stage with a sticky overrun flag.
module pdm_decimator #(
    parameter int DECIM = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pdm_in,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic        overrun
);
    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = 2 + 3 * LOG2D;
    localparam int SHIFT = 3 * LOG2D - 15;

    localparam logic signed [ACC_W-1:0] MAX_PCM = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_PCM = -ACC_W'(32768);
    localparam logic [LOG2D-1:0]        CNT_TOP = LOG2D'(DECIM - 1);

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] i1, i2, i3;
    logic [ACC_W-1:0] d1, d2, d3;
    logic [ACC_W-1:0] c1, c2, c3;
    logic [ACC_W-1:0] comb_res;
    logic [LOG2D-1:0] dec_cnt;
    logic [1:0]       warm;
    logic             strobe;
    logic             sample_pend;
    logic signed [ACC_W-1:0] scaled;
    logic [15:0]      sat;

    // +1 / -1 input symbol; every integrator and comb wraps modulo 2^ACC_W,
    // which the CIC relies on for exact results.
    assign x      = pdm_in ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    assign strobe = (dec_cnt == CNT_TOP);

    // Comb differences use the pre-edge I3 and delay values.
    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    // Scale the comb output to 16 bits and clamp full-scale positive to 32767.
    always_comb begin
        scaled = $signed(comb_res) >>> SHIFT;
        sat    = scaled[15:0];
        if (scaled > MAX_PCM)
            sat = 16'h7fff;
        else if (scaled < MIN_PCM)
            sat = 16'h8000;
    end

    // Integrator cascade, updated every oversampled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            i1 <= i1 + x;
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    // Decimation counter; natural wrap at DECIM since DECIM is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dec_cnt <= '0;
        else
            dec_cnt <= dec_cnt + LOG2D'(1);
    end

    // Comb section and warm-up: the first three strobes only prime the delays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1          <= '0;
            d2          <= '0;
            d3          <= '0;
            comb_res    <= '0;
            warm        <= '0;
            sample_pend <= 1'b0;
        end else begin
            sample_pend <= strobe && (warm == 2'd3);
            if (strobe) begin
                d1       <= i3;
                d2       <= c1;
                d3       <= c2;
                comb_res <= c3;
                if (warm != 2'd3)
                    warm <= warm + 2'd1;
            end
        end
    end

    // Output register with handshake; a pending sample always wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (sample_pend) begin
            pcm_out   <= sat;
            pcm_valid <= 1'b1;
            if (pcm_valid && !pcm_ready)
                overrun <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: table of constant/periodic PDM patterns checked through a
// sample scoreboard, plus hand-written backpressure, simultaneous-accept and
// mid-run-reset sequences.
module tb_pdm_decimator;
    localparam int DECIM = 128;
    localparam int FIRST = 4 * DECIM;   // edge after which pcm_valid first rises

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pdm_in = 1'b0;
    logic        pcm_ready = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int popped = 0;
    logic mon_en = 1'b0;
    int sb[$];

    typedef struct {
        int    mode;
        int    nsamp;
        int    expect_pcm;
        string name;
    } vec_t;

    pdm_decimator #(.DECIM(DECIM)) dut (
        .clk       (clk),
        .reset     (reset),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (n % 2) == 0;
            3:       return (n % 4) != 3;
            4:       return (n % 4) == 0;
            5:       return (n % 4) < 2;
            default: return (n % 8) != 7;
        endcase
    endfunction

    // Scoreboard consumer: every handshake pops one expected sample.
    always @(negedge clk) begin
        if (mon_en && !reset && pcm_valid && pcm_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=%0d expected=none", $signed(pcm_out));
            end else begin
                chk("sample", $signed(pcm_out), sb.pop_front());
            end
            popped++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        pdm_in = 1'b0;
        pcm_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one edge's inputs, then sample 1 time unit after that edge.
    task automatic step(input logic b, input logic rdy);
        pdm_in = b;
        pcm_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[7];
        int first;
        vecs[0] = '{0, 3,  32767, "ones"};
        vecs[1] = '{1, 3, -32768, "zeros"};
        vecs[2] = '{2, 3,      0, "alt10"};
        vecs[3] = '{3, 3,  16384, "p1110"};
        vecs[4] = '{4, 3, -16384, "p1000"};
        vecs[5] = '{5, 3,      0, "p1100"};
        vecs[6] = '{6, 3,  24576, "p11111110"};

        // Reset state
        #2;
        chk("reset_pcm_out", $signed(pcm_out), 0);
        chk("reset_valid", pcm_valid, 0);
        chk("reset_overrun", overrun, 0);

        // Table-driven patterns with pcm_ready held high
        foreach (vecs[v]) begin
            do_reset();
            sb.delete();
            for (int k = 0; k < vecs[v].nsamp; k++) sb.push_back(vecs[v].expect_pcm);
            popped = 0;
            first = -1;
            mon_en = 1'b1;
            for (int n = 0; n <= (3 + vecs[v].nsamp) * DECIM; n++) begin
                step(pat(vecs[v].mode, n), 1'b1);
                if (first < 0 && pcm_valid) first = n;
            end
            @(negedge clk);
            #1;
            mon_en = 1'b0;
            chk({vecs[v].name, "_first_valid_edge"}, first, FIRST);
            chk({vecs[v].name, "_sample_count"}, popped, vecs[v].nsamp);
            chk({vecs[v].name, "_overrun"}, overrun, 0);
        end

        // Backpressure: two samples with pcm_ready low, then one accept cycle
        do_reset();
        for (int n = 0; n <= FIRST; n++) begin
            step(1'b1, 1'b0);
            if (n == FIRST - 1) chk("bp_valid_before_first", pcm_valid, 0);
        end
        chk("bp_valid_first", pcm_valid, 1);
        chk("bp_pcm_first", $signed(pcm_out), 32767);
        chk("bp_overrun_first", overrun, 0);
        for (int n = FIRST + 1; n <= FIRST + 60; n++) step(1'b1, 1'b0);
        chk("bp_valid_hold", pcm_valid, 1);
        chk("bp_pcm_hold", $signed(pcm_out), 32767);
        chk("bp_overrun_hold", overrun, 0);
        for (int n = FIRST + 61; n <= FIRST + DECIM; n++) step(1'b1, 1'b0);
        chk("bp_valid_second", pcm_valid, 1);
        chk("bp_overrun_second", overrun, 1);
        step(1'b1, 1'b1);
        chk("bp_valid_after_accept", pcm_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);
        repeat (5) step(1'b1, 1'b0);
        chk("bp_overrun_sticky_later", overrun, 1);

        // Accept on the same edge that loads the next sample
        do_reset();
        for (int n = 0; n < FIRST + DECIM; n++) step(1'b1, 1'b0);
        chk("sim_valid_pre", pcm_valid, 1);
        step(1'b1, 1'b1);
        chk("sim_valid_load", pcm_valid, 1);
        chk("sim_overrun_load", overrun, 0);
        step(1'b1, 1'b0);
        chk("sim_valid_after", pcm_valid, 1);
        chk("sim_overrun_after", overrun, 0);

        // Mid-run reset clears outputs immediately and restarts warm-up
        do_reset();
        for (int n = 0; n <= FIRST + DECIM + 60; n++) step(1'b1, 1'b0);
        chk("mrr_overrun_before", overrun, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrr_pcm_zero", $signed(pcm_out), 0);
        chk("mrr_valid_zero", pcm_valid, 0);
        chk("mrr_overrun_zero", overrun, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n <= FIRST; n++) begin
            step(1'b1, 1'b1);
            if (n == 100) chk("mrr_no_stale_valid", pcm_valid, 0);
            if (n == FIRST - 1) chk("mrr_valid_before_first", pcm_valid, 0);
        end
        chk("mrr_valid_first", pcm_valid, 1);
        chk("mrr_pcm_first", $signed(pcm_out), 32767);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
